learn_note_feeder: RTL and testbench

LEARN_NOTE_FEEDER -- requirements
Module: learn_note_feeder

---
 rtl/learn_note_feeder_pkg.sv | 25 ++
 rtl/learn_note_feeder_if.sv | 29 ++
 rtl/learn_note_feeder.sv | 99 +++++++++
 tb/tb_learn_note_feeder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/learn_note_feeder_pkg.sv
// Shared types and constants for the learn-mode note feeder: FSM encoding,
// ROM word layout and default geometry.
package learn_note_feeder_pkg;

  localparam int unsigned OFFS_W_DEF = 8;
  localparam int unsigned SEL_W_DEF  = 2;
  localparam int unsigned NOTE_W     = 10;
  localparam int unsigned END_BIT    = 10;
  localparam int unsigned ROM_W      = END_BIT + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Bit 10 flags end-of-song; the low bits are {8 one-hot buttons, 2-bit octave}.
  typedef struct packed {
    logic              end_mark;
    logic [NOTE_W-1:0] note;
  } rom_word_t;

endpackage

// File: rtl/learn_note_feeder_if.sv
// Bundle between the note feeder, its song ROM and the learn-mode consumer.
interface learn_note_feeder_if
  import learn_note_feeder_pkg::*;
#(
  parameter int unsigned OFFS_W = OFFS_W_DEF,
  parameter int unsigned SEL_W  = SEL_W_DEF
);

  logic                    start;
  logic [SEL_W-1:0]        song_sel;
  logic                    read_en;
  logic [SEL_W+OFFS_W-1:0] rom_addr;
  rom_word_t               rom_data;
  logic [NOTE_W-1:0]       data_out;
  logic                    note_valid;
  logic                    song_done;
  logic [OFFS_W-1:0]       note_index;

  modport master (
    output start, song_sel, read_en, rom_data,
    input  rom_addr, data_out, note_valid, song_done, note_index
  );

  modport slave (
    input  start, song_sel, read_en, rom_data,
    output rom_addr, data_out, note_valid, song_done, note_index
  );

endinterface

// File: rtl/learn_note_feeder.sv
// Walks one song in a synchronous ROM, presenting each note until the
// consumer acknowledges it; stops at the end marker or at the last slot.
module learn_note_feeder
  import learn_note_feeder_pkg::*;
#(
  parameter int unsigned OFFS_W = OFFS_W_DEF,
  parameter int unsigned SEL_W  = SEL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  learn_note_feeder_if.slave bus
);

  localparam logic [OFFS_W-1:0] OFFS_MAX = {OFFS_W{1'b1}};

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   song_q, song_d;
  logic [OFFS_W-1:0]  offset_q, offset_d;
  logic [NOTE_W-1:0]  data_q, data_d;
  logic [OFFS_W-1:0]  index_q, index_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      song_q   <= '0;
      offset_q <= '0;
      data_q   <= '0;
      index_q  <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      song_q   <= song_d;
      offset_q <= offset_d;
      data_q   <= data_d;
      index_q  <= index_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  // start overrides every state, including a pending acknowledge.
  always_comb begin
    state_d  = state_q;
    song_d   = song_q;
    offset_d = offset_q;
    data_d   = data_q;
    index_d  = index_q;
    valid_d  = valid_q;
    done_d   = done_q;

    if (bus.start) begin
      state_d  = ST_LOAD;
      song_d   = bus.song_sel;
      offset_d = '0;
      valid_d  = 1'b0;
      done_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_LOAD: state_d = ST_CHECK;
        ST_CHECK: begin
          if (bus.rom_data.end_mark) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            data_d  = bus.rom_data.note;
            index_d = offset_q;
            valid_d = 1'b1;
            state_d = ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (bus.read_en) begin
            valid_d = 1'b0;
            // The last slot ends the song rather than spilling into the next one.
            if (offset_q == OFFS_MAX) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              offset_d = offset_q + OFFS_W'(1);
              state_d  = ST_LOAD;
            end
          end
        end
        ST_IDLE, ST_DONE: state_d = state_q;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.rom_addr   = {song_q, offset_q};
  assign bus.data_out   = data_q;
  assign bus.note_valid = valid_q;
  assign bus.song_done  = done_q;
  assign bus.note_index = index_q;

endmodule

// File: tb/tb_learn_note_feeder.sv
// Self-checking bench for learn_note_feeder with a synchronous ROM model and
// a song-level reference of the expected note sequence.
module tb_learn_note_feeder;
  import learn_note_feeder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  learn_note_feeder_if bus ();

  learn_note_feeder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [10:0] rom_mem [0:1023];
  always @(posedge clk) bus.rom_data <= rom_word_t'(rom_mem[bus.rom_addr]);

  int errors = 0;
  int checks = 0;

  // Counts cycles where the address leaves the song under watch.
  bit       watch = 1'b0;
  bit [1:0] watch_song;
  int       addr_escape = 0;
  always @(negedge clk) if (watch && bus.rom_addr[9:8] != watch_song) addr_escape++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_song(input int s, input int len);
    for (int i = 0; i < 256; i++) rom_mem[s*256+i] = {1'b0, 10'($urandom)};
    if (len < 256) rom_mem[s*256+len] = 11'h400;
  endtask

  task automatic do_start(input int s);
    bus.song_sel = 2'(s);
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic wait_live(output bit ok);
    for (int i = 0; i < 20 && !(bus.note_valid || bus.song_done); i++) tick();
    ok = bus.note_valid || bus.song_done;
  endtask

  task automatic ack();
    bus.read_en = 1'b1;
    tick();
    bus.read_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; bus.read_en = 1'b0; bus.song_sel = '0;
    #12;
    checks++;
    if ({bus.note_valid, bus.song_done, bus.data_out, bus.note_index, bus.rom_addr} !== 30'h0) begin
      errors++;
      $display("FAIL reset_outputs: got nv=%b sd=%b do=%h ix=%h ad=%h, want all 0",
               bus.note_valid, bus.song_done, bus.data_out, bus.note_index, bus.rom_addr);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_first_note();
    fill_song(1, 256);
    rom_mem[10'h100] = 11'h081;
    do_start(1);
    checks++;
    if (bus.rom_addr !== 10'h100 || bus.note_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_addr: got ad=%h nv=%b, want ad=100 nv=0", bus.rom_addr, bus.note_valid);
    end
    tick();
    checks++;
    if (bus.note_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_early: got nv=%b, want 0 one cycle after start", bus.note_valid);
    end
    tick();
    checks++;
    if (bus.note_valid !== 1'b1 || bus.data_out !== 10'h081 || bus.note_index !== 8'h00) begin
      errors++;
      $display("FAIL first_note: got nv=%b do=%h ix=%h, want nv=1 do=081 ix=00",
               bus.note_valid, bus.data_out, bus.note_index);
    end
  endtask

  task automatic test_song_walk(input int s, input int len);
    logic [9:0]  exp [$];
    logic [10:0] w;
    bit          ok;
    fill_song(s, len);
    for (int o = 0; o < 256; o++) begin
      w = rom_mem[s*256+o];
      if (w[10]) break;
      exp.push_back(w[9:0]);
    end
    do_start(s);
    checks++;
    if (bus.song_done !== 1'b0 || bus.note_valid !== 1'b0) begin
      errors++;
      $display("FAIL walk_start_clear: got sd=%b nv=%b, want 0 0", bus.song_done, bus.note_valid);
    end
    for (int k = 0; k < exp.size(); k++) begin
      wait_live(ok);
      checks++;
      if (!ok || bus.note_valid !== 1'b1 || bus.data_out !== exp[k] || bus.note_index !== 8'(k)) begin
        errors++;
        $display("FAIL walk_note%0d: got nv=%b do=%h ix=%h, want nv=1 do=%h ix=%h",
                 k, bus.note_valid, bus.data_out, bus.note_index, exp[k], 8'(k));
      end
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
        tick();
        checks++;
        if (bus.note_valid !== 1'b1 || bus.data_out !== exp[k]) begin
          errors++;
          $display("FAIL walk_hold%0d: got nv=%b do=%h, want nv=1 do=%h",
                   k, bus.note_valid, bus.data_out, exp[k]);
        end
      end
      ack();
      checks++;
      if (bus.note_valid !== 1'b0) begin
        errors++;
        $display("FAIL walk_drop%0d: got nv=%b, want 0 after ack", k, bus.note_valid);
      end
    end
    wait_live(ok);
    checks++;
    if (!ok || bus.song_done !== 1'b1 || bus.note_valid !== 1'b0 ||
        (exp.size() > 0 && bus.data_out !== exp[exp.size()-1])) begin
      errors++;
      $display("FAIL walk_done: got sd=%b nv=%b do=%h, want sd=1 nv=0 last note held",
               bus.song_done, bus.note_valid, bus.data_out);
    end
  endtask

  task automatic test_read_en_held();
    bus.read_en = 1'b1;
    rst_n = 1'b0; #3; rst_n = 1'b1;
    fill_song(0, 256);
    tick(); tick();
    checks++;
    if (bus.note_valid !== 1'b0 || bus.rom_addr !== 10'h000) begin
      errors++;
      $display("FAIL held_idle: got nv=%b ad=%h, want nv=0 ad=000", bus.note_valid, bus.rom_addr);
    end
    do_start(0);
    tick();
    checks++;
    if (bus.rom_addr !== 10'h000 || bus.note_valid !== 1'b0) begin
      errors++;
      $display("FAIL held_load: got ad=%h nv=%b, want ad=000 nv=0", bus.rom_addr, bus.note_valid);
    end
    tick();
    checks++;
    if (bus.note_valid !== 1'b1 || bus.note_index !== 8'h00 || bus.data_out !== rom_mem[0][9:0]) begin
      errors++;
      $display("FAIL held_present: got nv=%b ix=%h do=%h, want nv=1 ix=00 do=%h",
               bus.note_valid, bus.note_index, bus.data_out, rom_mem[0][9:0]);
    end
    tick();
    checks++;
    if (bus.note_valid !== 1'b0 || bus.rom_addr !== 10'h001) begin
      errors++;
      $display("FAIL held_one_cycle: got nv=%b ad=%h, want nv=0 ad=001", bus.note_valid, bus.rom_addr);
    end
    tick(); tick();
    checks++;
    if (bus.note_valid !== 1'b1 || bus.note_index !== 8'h01) begin
      errors++;
      $display("FAIL held_second: got nv=%b ix=%h, want nv=1 ix=01", bus.note_valid, bus.note_index);
    end
    bus.read_en = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok;
    fill_song(1, 256);
    fill_song(2, 256);
    watch_song = 2'd1;
    do_start(1);
    watch = 1'b1;
    for (int k = 0; k < 256; k++) begin
      wait_live(ok);
      checks++;
      if (!ok || bus.note_valid !== 1'b1 || bus.note_index !== 8'(k) ||
          bus.data_out !== rom_mem[256+k][9:0]) begin
        errors++;
        $display("FAIL wrap_note%0d: got nv=%b ix=%h do=%h, want nv=1 ix=%h do=%h",
                 k, bus.note_valid, bus.note_index, bus.data_out, 8'(k), rom_mem[256+k][9:0]);
      end
      ack();
    end
    wait_live(ok);
    tick(); tick();
    watch = 1'b0;
    checks++;
    if (!ok || bus.song_done !== 1'b1 || bus.note_valid !== 1'b0 || addr_escape != 0) begin
      errors++;
      $display("FAIL wrap_done: got sd=%b nv=%b escapes=%0d, want sd=1 nv=0 escapes=0",
               bus.song_done, bus.note_valid, addr_escape);
    end
  endtask

  task automatic test_override();
    bit ok;
    fill_song(0, 256);
    fill_song(3, 256);
    do_start(0);
    for (int k = 0; k < 5; k++) begin
      wait_live(ok);
      ack();
    end
    wait_live(ok);
    checks++;
    if (!ok || bus.note_valid !== 1'b1 || bus.note_index !== 8'h05) begin
      errors++;
      $display("FAIL ovr_reach5: got nv=%b ix=%h, want nv=1 ix=05", bus.note_valid, bus.note_index);
    end
    bus.song_sel = 2'd3; bus.start = 1'b1; bus.read_en = 1'b1;
    tick();
    bus.start = 1'b0; bus.read_en = 1'b0;
    checks++;
    if (bus.rom_addr !== 10'h300 || bus.song_done !== 1'b0 || bus.note_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_start: got ad=%h sd=%b nv=%b, want ad=300 sd=0 nv=0",
               bus.rom_addr, bus.song_done, bus.note_valid);
    end
    tick(); tick();
    checks++;
    if (bus.note_valid !== 1'b1 || bus.note_index !== 8'h00 || bus.data_out !== rom_mem[10'h300][9:0]) begin
      errors++;
      $display("FAIL ovr_first: got nv=%b ix=%h do=%h, want nv=1 ix=00 do=%h",
               bus.note_valid, bus.note_index, bus.data_out, rom_mem[10'h300][9:0]);
    end
  endtask

  task automatic test_async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.note_valid, bus.song_done, bus.data_out, bus.note_index, bus.rom_addr} !== 30'h0) begin
      errors++;
      $display("FAIL async_rst: got nv=%b sd=%b do=%h ix=%h ad=%h, want all 0 before any edge",
               bus.note_valid, bus.song_done, bus.data_out, bus.note_index, bus.rom_addr);
    end
    #2;
    rst_n = 1'b1;
    bus.read_en = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (bus.note_valid !== 1'b0 || bus.rom_addr !== 10'h000 || bus.data_out !== 10'h000) begin
      errors++;
      $display("FAIL async_idle: got nv=%b ad=%h do=%h, want nv=0 ad=000 do=000",
               bus.note_valid, bus.rom_addr, bus.data_out);
    end
    bus.read_en = 1'b0;
    do_start(2);
    tick(); tick();
    checks++;
    if (bus.note_valid !== 1'b1 || bus.data_out !== rom_mem[10'h200][9:0]) begin
      errors++;
      $display("FAIL async_restart: got nv=%b do=%h, want nv=1 do=%h",
               bus.note_valid, bus.data_out, rom_mem[10'h200][9:0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = 11'h000;
    bus.rom_data = '0;
    test_reset();
    test_first_note();
    test_song_walk(2, 3);
    test_song_walk(0, int'($urandom_range(4, 12)));
    test_read_en_held();
    test_wrap();
    test_override();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
